// File: rtl/mips_cycle_sequencer.sv
// +----------------------------------------------------------------------------+
// | mips_cycle_sequencer: multi-cycle FETCH/EXEC/MEM control for the MIPS core |
// | Optional bus watchdog: define BUS_TIMEOUT_EN.        Revision: 1.0         |
// +----------------------------------------------------------------------------+
`default_nettype none

module mips_cycle_sequencer #(
   parameter int IRET_W         = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clk_enable,
   input  logic              waitrequest,
   input  logic              pc_is_zero,
   input  logic              is_load,
   input  logic              is_store,
   input  logic              regwrite,
   output logic              instr_read,
   output logic              data_read,
   output logic              data_write,
   output logic              ir_load,
   output logic              pc_en,
   output logic              reg_we,
   output logic              active,
   output logic              fault,
   output logic [IRET_W-1:0] iret_count
);

   localparam logic [2:0] c_IDLE   = 3'd0;
   localparam logic [2:0] c_FETCH  = 3'd1;
   localparam logic [2:0] c_EXEC   = 3'd2;
   localparam logic [2:0] c_MEM    = 3'd3;
   localparam logic [2:0] c_HALTED = 3'd4;
`ifdef BUS_TIMEOUT_EN
   localparam logic [2:0] c_FAULT  = 3'd5;
`endif

   localparam int              c_WCNT_W      = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                                               $clog2(TIMEOUT_CYCLES + 1) : 8;
   localparam logic [c_WCNT_W-1:0] c_TIMEOUT_LIM = c_WCNT_W'(TIMEOUT_CYCLES);

   logic [2:0]        r_state;
   logic [2:0]        w_next;
   logic [IRET_W-1:0] r_iret;
   logic              w_strobe;
   logic              w_wait;

   assign w_strobe = instr_read | data_read | data_write;
   // waitrequest only matters while a bus request is actually outstanding
   assign w_wait   = waitrequest & w_strobe;

   always_comb begin
      w_next     = r_state;
      instr_read = 1'b0;
      data_read  = 1'b0;
      data_write = 1'b0;
      ir_load    = 1'b0;
      pc_en      = 1'b0;
      reg_we     = 1'b0;
      case (r_state)
         c_IDLE: w_next = c_FETCH;
         c_FETCH: begin
            if (pc_is_zero) begin
               w_next = c_HALTED;
            end else begin
               instr_read = 1'b1;
               if (!waitrequest) begin
                  ir_load = clk_enable;
                  w_next  = c_EXEC;
               end
            end
         end
         c_EXEC: begin
            if (is_load | is_store) begin
               w_next = c_MEM;
            end else begin
               pc_en  = clk_enable;
               reg_we = clk_enable & regwrite;
               w_next = c_FETCH;
            end
         end
         c_MEM: begin
            // store wins over load when both decode bits are set
            data_write = is_store;
            data_read  = is_load & ~is_store;
            if (!(waitrequest & (is_load | is_store))) begin
               pc_en  = clk_enable;
               reg_we = clk_enable & regwrite & is_load & ~is_store;
               w_next = c_FETCH;
            end
         end
         default: w_next = r_state;
      endcase
   end

`ifdef BUS_TIMEOUT_EN
   logic [c_WCNT_W-1:0] r_wait_cnt;
   logic [2:0]          w_next_t;

   assign w_next_t = (w_wait && r_wait_cnt == c_TIMEOUT_LIM) ? c_FAULT : w_next;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wait_cnt <= '0;
      end else if (clk_enable) begin
         if (w_next_t != r_state)
            r_wait_cnt <= '0;
         else if (w_wait)
            r_wait_cnt <= r_wait_cnt + 1'b1;
      end
   end

   assign fault = (r_state == c_FAULT);
`else
   logic [2:0] w_next_t;
   logic       w_unused_timeout;

   assign w_next_t         = w_next;
   assign w_unused_timeout = |c_TIMEOUT_LIM | w_wait;
   assign fault            = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= c_IDLE;
         r_iret  <= '0;
      end else if (clk_enable) begin
         r_state <= w_next_t;
         if (pc_en)
            r_iret <= r_iret + 1'b1;
      end
   end

   assign active     = (r_state == c_FETCH) || (r_state == c_EXEC) || (r_state == c_MEM);
   assign iret_count = r_iret;

endmodule

`default_nettype wire

// File: tb/tb_mips_cycle_sequencer.sv
// +----------------------------------------------------------------------------+
// | tb_mips_cycle_sequencer: directed checks of the MIPS cycle sequencer       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_mips_cycle_sequencer;

   localparam int c_TO = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        clk_enable;
   logic        waitrequest;
   logic        pc_is_zero;
   logic        is_load;
   logic        is_store;
   logic        regwrite;
   logic        instr_read;
   logic        data_read;
   logic        data_write;
   logic        ir_load;
   logic        pc_en;
   logic        reg_we;
   logic        active;
   logic        fault;
   logic [31:0] iret_count;

   int n_tests = 0;
   int n_fail  = 0;

   // {instr_read, data_read, data_write, ir_load, pc_en, reg_we, active}
   logic [6:0] w_outs;
   assign w_outs = {instr_read, data_read, data_write, ir_load, pc_en, reg_we, active};

   mips_cycle_sequencer #(
      .IRET_W         (32),
      .TIMEOUT_CYCLES (c_TO)
   ) u_dut (
      .clk         (clk),
      .reset       (reset),
      .clk_enable  (clk_enable),
      .waitrequest (waitrequest),
      .pc_is_zero  (pc_is_zero),
      .is_load     (is_load),
      .is_store    (is_store),
      .regwrite    (regwrite),
      .instr_read  (instr_read),
      .data_read   (data_read),
      .data_write  (data_write),
      .ir_load     (ir_load),
      .pc_en       (pc_en),
      .reg_we      (reg_we),
      .active      (active),
      .fault       (fault),
      .iret_count  (iret_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // advance one edge; inputs are changed afterwards and outputs settle by +1
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic wr, input logic ld, input logic st, input logic rw);
      waitrequest = wr;
      is_load     = ld;
      is_store    = st;
      regwrite    = rw;
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
      #1;
   endtask

   initial begin
      reset = 1'b1; clk_enable = 1'b1; pc_is_zero = 1'b0;
      set_in(1'b0, 1'b0, 1'b0, 1'b0);
      #10;
      chk("reset_outs", {25'd0, w_outs}, 32'h0);
      chk("reset_fault", {31'd0, fault}, 32'h0);
      chk("reset_iret", iret_count, 32'd0);
      reset = 1'b0;
      #1;
      chk("idle_outs", {25'd0, w_outs}, 32'h0);

      // three ALU instructions, no wait states
      step();
      set_in(1'b0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         chk("alu_fetch", {25'd0, w_outs}, 32'h49);
         step();
         chk("alu_exec", {25'd0, w_outs}, 32'h07);
         step();
      end
      chk("alu_iret3", iret_count, 32'd3);

      // load: 4 fetch waits, 2 mem waits
      set_in(1'b1, 1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) begin
         chk("ld_fetch_wait", {25'd0, w_outs}, 32'h41);
         step();
      end
      set_in(1'b0, 1'b1, 1'b0, 1'b1);
      chk("ld_fetch_done", {25'd0, w_outs}, 32'h49);
      step();
      chk("ld_exec", {25'd0, w_outs}, 32'h01);
      step();
      set_in(1'b1, 1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 2; i++) begin
         chk("ld_mem_wait", {25'd0, w_outs}, 32'h21);
         step();
      end
      set_in(1'b0, 1'b1, 1'b0, 1'b1);
      chk("ld_mem_done", {25'd0, w_outs}, 32'h27);
      step();
      chk("ld_iret4", iret_count, 32'd4);

      // store, then load+store together: store wins, no register write
      for (int k = 0; k < 2; k++) begin
         set_in(1'b0, k == 1, 1'b1, 1'b1);
         chk("st_fetch", {25'd0, w_outs}, 32'h49);
         step();
         chk("st_exec", {25'd0, w_outs}, 32'h01);
         step();
         chk("st_mem", {25'd0, w_outs}, 32'h15);
         step();
      end
      chk("st_iret6", iret_count, 32'd6);

      // clk_enable low mid-MEM holds the request and suppresses the retire
      set_in(1'b0, 1'b1, 1'b0, 1'b1);
      step();
      step();
      clk_enable = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         chk("stall_mem", {25'd0, w_outs}, 32'h21);
         step();
      end
      chk("stall_iret", iret_count, 32'd6);
      clk_enable = 1'b1;
      #1;
      chk("stall_release", {25'd0, w_outs}, 32'h27);
      step();
      chk("stall_iret7", iret_count, 32'd7);

      // PC reaches zero: halt without issuing a read
      pc_is_zero = 1'b1;
      #1;
      chk("halt_fetch", {25'd0, w_outs}, 32'h01);
      step();
      chk("halted_outs", {25'd0, w_outs}, 32'h0);
      pc_is_zero = 1'b0;
      for (int i = 0; i < 4; i++) begin
         clk_enable = i[0];
         step();
      end
      clk_enable = 1'b1;
      #1;
      chk("halted_hold", {25'd0, w_outs}, 32'h0);
      chk("halted_iret", iret_count, 32'd7);

      // asynchronous reset in the middle of a fetch
      do_reset();
      clk_enable = 1'b0;
      step();
      chk("idle_stall", {25'd0, w_outs}, 32'h0);
      clk_enable = 1'b1;
      step();
      set_in(1'b1, 1'b0, 1'b0, 1'b1);
      chk("rst_fetch", {25'd0, w_outs}, 32'h41);
      reset = 1'b1;
      #1;
      chk("rst_async_outs", {25'd0, w_outs}, 32'h0);
      chk("rst_async_iret", iret_count, 32'd0);
      step();
      reset = 1'b0;
      set_in(1'b0, 1'b0, 1'b0, 1'b1);
      step();
      step();
      chk("restart_exec", {25'd0, w_outs}, 32'h07);
      step();
      chk("restart_iret", iret_count, 32'd1);

`ifdef BUS_TIMEOUT_EN
      // stuck bus: the fifth wait cycle sends the sequencer to FAULT
      do_reset();
      step();
      set_in(1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         chk("to_wait_fault", {31'd0, fault}, 32'h0);
         step();
      end
      chk("to_fault", {31'd0, fault}, 32'h1);
      chk("to_fault_outs", {25'd0, w_outs}, 32'h0);
      // release after exactly the limit completes normally
      do_reset();
      step();
      set_in(1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) step();
      set_in(1'b0, 1'b0, 1'b0, 1'b0);
      chk("to_edge_done", {25'd0, w_outs}, 32'h49);
      step();
      chk("to_edge_exec", {25'd0, w_outs}, 32'h05);
      chk("to_edge_fault", {31'd0, fault}, 32'h0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/mips_cycle_sequencer.md
Name: mips_cycle_sequencer

Overview:
Multi-cycle control sequencer for the MIPS CPU datapath. Orders each instruction into fetch, execute and optional memory phases over a shared Avalon-style bus with waitrequest. Generates the datapath enables: PC register enable, instruction-register load and register-file write qualifier. Drives the CPU-level active/halt status and a retired-instruction counter.

Parameters:
IRET_W, 32, width of retired-instruction counter
TIMEOUT_CYCLES, 255, max consecutive waitrequest cycles before fault (used only with the optional feature)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous active-high reset
clk_enable  input  1  global stall; 0 freezes sequencer state
waitrequest  input  1  bus stall for the current read/write
pc_is_zero  input  1  datapath PC equals 32'h0 (halt address)
is_load  input  1  decoded instruction is a load (valid in EXEC)
is_store  input  1  decoded instruction is a store (valid in EXEC)
regwrite  input  1  decoded instruction writes a register
instr_read  output  1  bus read strobe for instruction fetch
data_read  output  1  bus read strobe for load
data_write  output  1  bus write strobe for store
ir_load  output  1  capture instr_readdata into instruction register
pc_en  output  1  advance PC register this cycle
reg_we  output  1  qualified register-file write enable
active  output  1  CPU running
fault  output  1  bus timeout fault (0 unless feature compiled in)
iret_count  output  IRET_W  retired-instruction count

Behaviour:
- States: IDLE, FETCH, EXEC, MEM, HALTED, plus FAULT (feature only). Encoding is free.
- Reset (asynchronous): state=IDLE. All outputs 0, iret_count=0. Strobes drop in the same cycle as reset assertion, including mid-transaction.
- IDLE: active=0. Go to FETCH on the first clk edge with reset low and clk_enable=1.
- FETCH, on entry edge: if pc_is_zero=1, go to HALTED; no read is issued.
- FETCH, otherwise: instr_read=1. While waitrequest=1, hold. In the cycle with waitrequest=0: ir_load=1, then go to EXEC next cycle. Fetch latency is 1 + number of waitrequest cycles.
- EXEC, no memory access: when is_load=0 and is_store=0, pc_en=1 and reg_we=regwrite. Retire the instruction and go to FETCH.
- EXEC, memory access: when is_load or is_store, go to MEM. pc_en=0, reg_we=0.
- MEM: data_write=is_store and data_read=is_load&~is_store. If both inputs are high, store wins and reg_we is suppressed for that instruction.
  - Hold while waitrequest=1.
  - In the waitrequest=0 cycle: pc_en=1, reg_we=regwrite&is_load&~is_store. Retire and go to FETCH.
- Cycle counts:
  - ALU/branch/jump instruction with no wait states: 2 cycles.
  - Load/store with no wait states: 3 cycles.
- HALTED: active=0, all strobes/enables 0. Absorbing state; only reset exits it.
- active=1 in FETCH, EXEC, MEM; 0 in IDLE, HALTED, FAULT.
- clk_enable=0 (any state):
  - State and iret_count hold.
  - pc_en, reg_we, ir_load are forced 0.
  - instr_read/data_read/data_write keep their current values, so bus requests stay stable.
- waitrequest is ignored when no strobe is asserted.
- Strobe, ir_load, pc_en and reg_we outputs are combinational from state and inputs. At most one strobe is high at any time.
- iret_count increments by 1 on every cycle with pc_en=1. It wraps modulo 2^IRET_W with no saturation.

Optional Feature:
Macro BUS_TIMEOUT_EN.
- Defined:
  - An 8-bit-or-wider wait counter clears on entry to FETCH or MEM.
  - It increments each clk_enable cycle with waitrequest=1 and a strobe high.
  - When the count reaches TIMEOUT_CYCLES with waitrequest still 1, go to FAULT next cycle.
  - FAULT: strobes 0, active=0, fault=1. Absorbing until reset.
  - A count of exactly TIMEOUT_CYCLES followed by waitrequest=0 completes normally.
- Undefined: no counter and no FAULT state; fault tied to 0; waits are unbounded.

Test Plan:
- Reset, then 3 ALU instructions with waitrequest=0 and regwrite=1 -> each instruction: instr_read 1 cycle, ir_load 1 cycle, pc_en and reg_we in the next cycle; iret_count=3 after 6 cycles plus IDLE.
- Load with waitrequest=1 for 4 cycles in FETCH and 2 cycles in MEM -> instr_read high 5 cycles, data_read high 3 cycles; single pc_en/reg_we pulse; total 9 cycles.
- Store with regwrite=1, then is_load=is_store=1 -> data_write asserted, data_read=0, reg_we=0 both times; pc_en pulses once each.
- pc_is_zero=1 on FETCH entry -> HALTED: active falls to 0, no instr_read, iret_count frozen; clk_enable toggling has no effect.
- clk_enable=0 for 3 cycles mid-MEM with waitrequest=0 -> data_read stays 1, pc_en=0; completes on the first enabled cycle. Async reset mid-FETCH -> instr_read=0 immediately, iret_count=0.
- BUS_TIMEOUT_EN with TIMEOUT_CYCLES=4 and waitrequest stuck at 1 -> fault=1 and active=0 on the 5th wait cycle. Same test with waitrequest released after exactly 4 wait cycles -> completes normally, fault=0.
